cos_result_fifo: RTL and testbench
==================================

# cos_result_fifo

Downstream buffer for the fixed-point cosine unit's result port. It detects each completion of the cosine unit (rising edge of its `done`) and captures the 10-bit result `{intpart, fracpart}` into a small show-ahead FIFO. It presents the results to the consumer over a valid/ready handshake, so back-to-back cosine evaluations are not lost while the consumer is busy. It also keeps a sticky overflow flag and a running maximum of all accepted results.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

**Ports**
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `clear`  in  1  synchronous flush of FIFO, overflow flag and maximum.
- `done`  in  1  completion level from the cosine unit.
- `intpart`  in  2  integer part of the cosine result.
- `fracpart`  in  8  fractional part of the cosine result.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  10  head entry, `{intpart, fracpart}`.
- `count`  out  AW+1  entries currently held, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a capture was dropped.
- `max_val`  out  10  largest `{intpart, fracpart}` accepted since reset or clear, compared unsigned.

## Operation

**Capture detect**
- Register `done_q <= done`.
- `push = done & ~done_q`.
- `done_q` resets to 1, so a `done` already high at reset release is not captured.
- `intpart` and `fracpart` are sampled in the push cycle.

**Storage**
- `DEPTH` × 10-bit memory, `wr_ptr` / `rd_ptr` of AW bits, and a `count` register.
- Pointers wrap naturally modulo `DEPTH`.

**Pop and output**
- `pop = out_valid & out_ready`.
- `out_valid = ~empty`.
- `out_data = mem[rd_ptr]` (show-ahead). When empty, `out_data` is don't-care and the bench does not check it.

**Push and pop rules**
- Push while not full: write `mem[wr_ptr]`, increment `wr_ptr`.
- Push while full without pop: the sample is dropped, `overflow <= 1`, and memory and pointers are unchanged.
- Push and pop in the same cycle:
  - Both proceed, and `count` is unchanged.
  - This holds even when full; it is not an overflow.
- Pop while empty is impossible, because `out_valid = 0`.

**Maximum**
- On every accepted push, `max_val <= max(max_val, new)`.
- Dropped samples do not update `max_val`.

**Clear**
- `clear` zeroes `wr_ptr`, `rd_ptr`, `count`, `overflow` and `max_val` on the next edge.
- It has priority over push and pop in the same cycle: the sample is lost and no overflow is flagged.
- `done_q` still updates normally.

**Reset**
- All pointers, `count`, `overflow` and `max_val` go to 0, and `done_q` goes to 1.
- Output reset values: `out_valid = 0`, `empty = 1`, `full = 0`, `count = 0`, `overflow = 0`, `max_val = 0`.
- Reset asserted mid-operation discards all contents immediately; this is asynchronous.

## Timing
- **Capture latency:** `done` rises in cycle N. The entry is written at the end of N, and `out_valid` / `count` reflect it from cycle N+1.
- **Pop:** consumed at the edge where `out_valid & out_ready`. The next head appears at the output in the following cycle.
- **Sustained `done`:** a level held high for many cycles produces exactly one entry. `done` must return low for at least 1 cycle before the next capture.
- **Throughput:** at most one push and one pop per cycle.
- **Overflow:** the flag asserts in the cycle after the dropped push and stays high until `clear` or reset.
- **Status outputs:** `full`, `empty` and `count` are registered-state derived and are never combinational from `out_ready`.

## Test plan
1. **Reset release with `done` high.** Hold `rst = 0` with `done = 1`, then release and keep `done = 1` for 10 cycles.
   - Required: `count` stays 0 and `out_valid` stays 0.
2. **Single capture.** Pulse `done` high for 5 cycles with `intpart = 2'b01`, `fracpart = 8'h80`, and `out_ready = 0`.
   - Required: exactly one entry; `out_data = 10'h180`; `count = 1`; `max_val = 10'h180`.
3. **Overflow.** With `DEPTH = 4` and `out_ready = 0`, issue 5 captures of values 10'h010, 10'h020, 10'h030, 10'h040, 10'h050.
   - Required: `full = 1` and `overflow = 1`; `max_val = 10'h040`.
   - Then drain with `out_ready = 1`: the outputs are 010, 020, 030, 040, then `empty = 1`.
4. **Push and pop while full.** Fill to 4 entries. Then, in one cycle, assert a push of 10'h1FF together with `out_ready = 1`.
   - Required: `count` stays 4 and `overflow` stays 0.
   - The last entry drained is 10'h1FF.
5. **Clear collides with push.** Assert `clear` in the same cycle as a `done` rising edge carrying 10'h2AA.
   - Required: next cycle `count = 0`, `max_val = 0`, `overflow = 0`, and 10'h2AA is never output.
6. **Async reset mid-stream.** Pull `rst` low mid-cycle while the FIFO holds 3 entries.
   - Required: `out_valid`, `count` and `max_val` go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cos_result_fifo.sv
// cos_result_fifo
// Buffers results of the fixed-point cosine unit. Each rising edge of the
// unit's done level captures {intpart, fracpart} into a show-ahead FIFO.
// The FIFO is drained over a valid/ready handshake. A sticky overflow flag
// records dropped captures. A running unsigned maximum tracks every accepted
// result.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   clear      synchronous flush of FIFO, overflow flag and maximum
//   done       completion level from the cosine unit
//   intpart    integer part of the result (2 bits)
//   fracpart   fractional part of the result (8 bits)
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_data   head entry {intpart, fracpart}
//   count      entries held, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: a capture was dropped
//   max_val    largest accepted result since reset/clear (unsigned)
module cos_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          done,
    input  logic [1:0]    intpart,
    input  logic [7:0]    fracpart,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [9:0]    out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [9:0]    max_val
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [9:0] umax(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          done_q;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [9:0]    din;

    assign din       = {intpart, fracpart};
    assign push      = done & ~done_q;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // A simultaneous pop frees the head slot, so a push into a full FIFO
    // is still accepted; when full, wr_ptr equals rd_ptr and the write
    // lands in the slot being consumed on this same edge.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    // Capture-detect register: resets high so a done already asserted
    // at reset release is not mistaken for a new completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= done;
        end
    end

    // Storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Control state: pointers, occupancy, overflow and running maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            max_val  <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            max_val  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                max_val <= umax(max_val, din);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_result_fifo.sv
module tb_cos_result_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          done;
    logic [1:0]    intpart;
    logic [7:0]    fracpart;
    logic          out_valid;
    logic          out_ready;
    logic [9:0]    out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [9:0]    max_val;

    cos_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .done      (done),
        .intpart   (intpart),
        .fracpart  (fracpart),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .max_val   (max_val)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted results plus flags.
    logic [9:0] q[$];
    logic       m_ovf;
    logic [9:0] m_max;
    logic       m_prev_done;
    logic [9:0] last_pop;
    int         nerr = 0;
    int         nchk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input logic [9:0] v);
        intpart  = v[9:8];
        fracpart = v[7:0];
    endtask

    task automatic model_update();
        logic       p;
        logic       pp;
        int         sz;
        logic [9:0] d;
        logic [9:0] tmp;
        if (!rst) begin
            q.delete();
            m_ovf       = 1'b0;
            m_max       = '0;
            m_prev_done = 1'b1;
        end else begin
            d  = {intpart, fracpart};
            p  = done && !m_prev_done;
            sz = q.size();
            pp = (sz != 0) && out_ready;
            if (clear) begin
                q.delete();
                m_ovf = 1'b0;
                m_max = '0;
            end else begin
                if (pp) begin
                    tmp      = q.pop_front();
                    last_pop = tmp;
                end
                if (p) begin
                    if (sz < DEPTH || pp) begin
                        q.push_back(d);
                        if (d > m_max) m_max = d;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_prev_done = done;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".max"}, 32'(max_val), 32'(m_max));
        if (q.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(q[0]));
    endtask

    // One capture: rising done for one cycle, then low for one cycle.
    task automatic capture(input logic [9:0] v, input string tag);
        set_val(v);
        done = 1'b1;
        step();
        check_all(tag);
        done = 1'b0;
        step();
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; done = 1'b1; out_ready = 1'b0;
        set_val(10'h000);
        q.delete(); m_ovf = 1'b0; m_max = '0; m_prev_done = 1'b1; last_pop = '0;

        // Reset state with done held high
        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.max", 32'(max_val), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1.count", 32'(count), 32'd0);
            chk("t1.valid", 32'(out_valid), 32'd0);
        end

        // Single capture from a 5-cycle done pulse
        done = 1'b0;
        step();
        intpart = 2'b01; fracpart = 8'h80; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("t2");
        end
        done = 1'b0;
        step();
        chk("t2.count", 32'(count), 32'd1);
        chk("t2.data", 32'(out_data), 32'h180);
        chk("t2.max", 32'(max_val), 32'h180);

        // Overflow on the fifth capture
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_all("t3.clr");
        for (int i = 1; i <= 5; i++) capture(10'(i * 16), "t3");
        chk("t3.full", 32'(full), 32'd1);
        chk("t3.ovf", 32'(overflow), 32'd1);
        chk("t3.max", 32'(max_val), 32'h040);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3.drain", 32'(out_data), 32'(i * 16));
            step();
            check_all("t3.d");
        end
        chk("t3.empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // Push and pop together while full
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) capture(10'($urandom_range(0, 10'h1FE)), "t4");
        chk("t4.full", 32'(full), 32'd1);
        set_val(10'h1FF); done = 1'b1; out_ready = 1'b1;
        step();
        check_all("t4.pp");
        chk("t4.count", 32'(count), 32'd4);
        chk("t4.ovf", 32'(overflow), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("t4.d");
        end
        chk("t4.last", 32'(last_pop), 32'h1FF);
        chk("t4.empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // Clear colliding with a capture
        capture(10'h055, "t5");
        capture(10'h066, "t5");
        set_val(10'h2AA); done = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; done = 1'b0;
        chk("t5.count", 32'(count), 32'd0);
        chk("t5.max", 32'(max_val), 32'd0);
        chk("t5.ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5.novalid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle with 3 entries held
        for (int i = 0; i < 3; i++) capture(10'($urandom_range(1, 10'h3FF)), "t6");
        chk("t6.count3", 32'(count), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        chk("t6.valid", 32'(out_valid), 32'd0);
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.max", 32'(max_val), 32'd0);
        chk("t6.empty", 32'(empty), 32'd1);
        step();
        rst = 1'b1;
        check_all("t6.post");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            done      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            set_val(10'($urandom_range(0, 10'h3FF)));
            step();
            check_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
